delay_line_mtap: RTL and testbench

//  Parametrised successor of the fixed 1-bit/15-tap delay: one shared shift history of

---
 rtl/delay_line_pkg.sv | 9 +
 rtl/delay_tap_mux.sv | 30 +++
 rtl/delay_line_mtap.sv | 65 ++++++
 tb/tb_delay_line_mtap.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/delay_line_pkg.sv
// Shared helpers for the multi-tap delay line.
package delay_line_pkg;

  // Bit width needed to encode a delay select of 0..max.
  function automatic int unsigned delay_w(input int unsigned max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/delay_tap_mux.sv
// One output tap of the delay line.
// Select 0 bypasses the history and passes the live input word.
// Selects above the deepest history entry clamp to that entry and raise o_err.
module delay_tap_mux #(
  parameter int unsigned WIDTH     = 9,
  parameter int unsigned MAX_DELAY = 15,
  parameter int unsigned DW        = 4
) (
  input  logic [WIDTH-1:0]           i_bypass,
  input  logic [MAX_DELAY*WIDTH-1:0] i_hist,
  input  logic [DW-1:0]              i_sel,
  output logic [WIDTH-1:0]           o_word,
  output logic                       o_err
);

  // Tap select: bypass, in-range history entry, or clamped deepest entry.
  always_comb begin
    o_word = i_bypass;
    o_err  = 1'b0;
    if (i_sel == '0) begin
      o_word = i_bypass;
    end else if (32'(i_sel) > MAX_DELAY) begin
      o_word = i_hist[(MAX_DELAY - 32'd1) * WIDTH +: WIDTH];
      o_err  = 1'b1;
    end else begin
      o_word = i_hist[(32'(i_sel) - 32'd1) * WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/delay_line_mtap.sv
// Multi-tap delay line: one shared {valid,data} shift history, CHANNELS
// independent run-time selectable taps, with a clock-enable stall.
module delay_line_mtap
  import delay_line_pkg::*;
#(
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned MAX_DELAY = 15,
  parameter  int unsigned CHANNELS  = 4,
  localparam int unsigned DW        = delay_w(MAX_DELAY)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic [WIDTH-1:0]          data_i,
  input  logic                      valid_i,
  input  logic [CHANNELS*DW-1:0]    delay_i,
  output logic [CHANNELS*WIDTH-1:0] data_o,
  output logic [CHANNELS-1:0]       valid_o,
  output logic [CHANNELS-1:0]       err_o
);

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
  } word_t;

  localparam int unsigned WW = WIDTH + 1;

  // Element k holds the word captured k+1 enabled edges ago (hist[k+1]).
  word_t [MAX_DELAY-1:0] r_hist;
  word_t                 w_in;
  word_t                 w_tap [CHANNELS];

  assign w_in = '{v: valid_i, d: data_i};

  // History shift register; reset clears every entry so taps fill with valid 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hist <= '0;
    end else if (en_i) begin
      r_hist[0] <= w_in;
      for (int unsigned k = 1; k < MAX_DELAY; k++) begin
        r_hist[k] <= r_hist[k-1];
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_tap
    delay_tap_mux #(
      .WIDTH     (WW),
      .MAX_DELAY (MAX_DELAY),
      .DW        (DW)
    ) u_tap (
      .i_bypass (w_in),
      .i_hist   (r_hist),
      .i_sel    (delay_i[c*DW +: DW]),
      .o_word   (w_tap[c]),
      .o_err    (err_o[c])
    );

    assign data_o[c*WIDTH +: WIDTH] = w_tap[c].d;
    assign valid_o[c]               = w_tap[c].v;
  end

endmodule

// File: tb/tb_delay_line_mtap.sv
// Self-checking bench for delay_line_mtap: a capture-log model checked every
// cycle, plus directed literal checks for fill, stall, reset and delay change.
module tb_delay_line_mtap;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [15:0] delay_i;
  logic [31:0] data_o;
  logic [3:0]  valid_o;
  logic [3:0]  err_o;

  // Second build with a non-2^n-1 depth so out-of-range selects exist.
  logic [3:0]  delay2_i;
  logic [7:0]  data2_o;
  logic [0:0]  valid2_o;
  logic [0:0]  err2_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  typedef logic [8:0] w_t;   // {valid, data}
  w_t mlog[$];               // mlog[0] = most recent enabled capture

  delay_line_mtap #(.WIDTH(8), .MAX_DELAY(15), .CHANNELS(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .data_i(data_i), .valid_i(valid_i),
    .delay_i(delay_i), .data_o(data_o), .valid_o(valid_o), .err_o(err_o)
  );

  delay_line_mtap #(.WIDTH(8), .MAX_DELAY(10), .CHANNELS(1)) dut10 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .data_i(data_i), .valid_i(valid_i),
    .delay_i(delay2_i), .data_o(data2_o), .valid_o(valid2_o), .err_o(err2_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void model_clear();
    mlog.delete();
    for (int i = 0; i < 15; i++) mlog.push_back(9'h000);
  endfunction

  function automatic w_t model_tap(input int d, input int max);
    if (d == 0)        return {valid_i, data_i};
    else if (d <= max) return mlog[d-1];
    else               return mlog[max-1];
  endfunction

  // Model update: reset clears, every enabled edge records the input word.
  always @(posedge rst_i) model_clear();
  always @(posedge clk_i) begin
    if (rst_i) model_clear();
    else if (en_i) begin
      mlog.push_front({valid_i, data_i});
      void'(mlog.pop_back());
    end
  end

  // Per-cycle compare of every tap of both builds against the model.
  always @(negedge clk_i) begin
    #2;
    if (chk_on) begin
      for (int c = 0; c < 4; c++) begin
        int   d;
        logic [9:0] got, exp;
        d   = int'(delay_i[c*4 +: 4]);
        exp = {1'b0, model_tap(d, 15)};
        got = {err_o[c], valid_o[c], data_o[c*8 +: 8]};
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL tap%0d d=%0d: got {err,v,data}=%h required %h at %0t", c, d, got, exp, $time);
        end
      end
      begin
        int   d2;
        logic [9:0] got2, exp2;
        d2   = int'(delay2_i);
        exp2 = {(d2 > 10) ? 1'b1 : 1'b0, model_tap(d2, 10)};
        got2 = {err2_o[0], valid2_o[0], data2_o};
        n_tests++;
        if (got2 !== exp2) begin
          n_fail++;
          $display("FAIL max10 d=%0d: got {err,v,data}=%h required %h at %0t", d2, got2, exp2, $time);
        end
      end
    end
  end

  task automatic lit(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic en, input logic v, input logic [7:0] d);
    @(negedge clk_i);
    en_i = en; valid_i = v; data_i = d;
    #3;
  endtask

  logic [31:0] held;

  initial begin
    rst_i = 1'b1; en_i = 1'b0; data_i = '0; valid_i = 1'b0;
    delay_i = {4'd15, 4'd7, 4'd1, 4'd0}; delay2_i = 4'd3;
    model_clear();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b0;
    chk_on = 1'b1;

    // Fill from reset with an incrementing stream.
    for (int n = 1; n <= 20; n++) begin
      step(1'b1, 1'b1, 8'(n));
      lit("tap0 bypass", {err_o[0], valid_o[0], data_o[7:0]}, {2'b01, 8'(n)});
      if (n == 1) lit("tap1 empty", {1'b0, valid_o[1], data_o[15:8]}, 10'h000);
      if (n == 2) lit("tap1 first", {1'b0, valid_o[1], data_o[15:8]}, 10'h101);
      if (n == 7) lit("tap2 empty", {1'b0, valid_o[2], 8'h00}, 10'h000);
      if (n == 8) lit("tap2 first", {1'b0, valid_o[2], data_o[23:16]}, 10'h101);
      if (n <= 15) lit("tap3 fill", {1'b0, valid_o[3], 8'h00}, 10'h000);
      if (n == 16) lit("tap3 first", {1'b0, valid_o[3], data_o[31:24]}, 10'h101);
      if (n == 17) lit("tap3 next", {1'b0, valid_o[3], data_o[31:24]}, 10'h102);
    end

    // Async reset between edges.
    step(1'b1, 1'b1, 8'h3C);
    rst_i = 1'b1;
    #1;
    lit("rst tap1", {1'b0, valid_o[1], data_o[15:8]}, 10'h000);
    lit("rst tap2", {1'b0, valid_o[2], data_o[23:16]}, 10'h000);
    lit("rst tap3", {1'b0, valid_o[3], data_o[31:24]}, 10'h000);
    lit("rst tap0 pass", {1'b0, valid_o[0], data_o[7:0]}, 10'h13C);
    @(negedge clk_i); rst_i = 1'b0;
    step(1'b1, 1'b1, 8'h77);
    step(1'b1, 1'b0, 8'h11);
    lit("post-rst capture", {1'b0, valid_o[1], data_o[15:8]}, 10'h177);

    // Stall with all taps at delay 5.
    delay_i = {4'd5, 4'd5, 4'd5, 4'd5};
    step(1'b1, 1'b1, 8'h5A);
    step(1'b1, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'hEE);
    held = data_o;
    step(1'b0, 1'b0, 8'hEF);
    lit("stall hold 2", {2'b00, data_o[7:0]}, {2'b00, held[7:0]});
    step(1'b0, 1'b1, 8'hF0);
    lit("stall hold 3", {2'b00, data_o[31:24]}, {2'b00, held[31:24]});
    for (int s = 1; s <= 5; s++) begin
      step(1'b1, 1'b1, 8'(s));
      if (s == 4) lit("stall pre-A5", {1'b0, valid_o[0], data_o[7:0]}, 10'h15A);
      if (s == 5) lit("stall A5", {1'b0, valid_o[2], data_o[23:16]}, 10'h1A5);
    end

    // Delay change on tap1 from 3 to 10; max-10 build driven out of range.
    delay_i = {4'd15, 4'd7, 4'd3, 4'd0};
    delay2_i = 4'd13;
    for (int j = 0; j < 12; j++) step(1'b1, 1'b1, 8'(8'h40 + j));
    lit("tap1 d3", {err_o[1], valid_o[1], data_o[15:8]}, 10'h148);
    delay_i[7:4] = 4'd10;
    #1;
    lit("tap1 d10 now", {err_o[1], valid_o[1], data_o[15:8]}, 10'h141);
    step(1'b1, 1'b1, 8'h4C);
    lit("tap1 d10", {err_o[1], valid_o[1], data_o[15:8]}, 10'h142);
    lit("max10 d13 clamp", {err2_o[0], valid2_o[0], data2_o}, 10'h342);

    // Randomized traffic.
    for (int r = 0; r < 400; r++) begin
      @(negedge clk_i);
      en_i     = ($urandom_range(0, 4) != 0);
      valid_i  = 1'($urandom);
      data_i   = 8'($urandom);
      if ($urandom_range(0, 7) == 0) delay_i = 16'($urandom);
      if ($urandom_range(0, 7) == 0) delay2_i = 4'($urandom);
      #3;
    end

    @(negedge clk_i);
    #4;
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
